// File: rtl/stack_cpu_core_if.sv
// Bus bundle for stack_cpu_core: instruction fetch, data memory and status.
//   pc         core -> env  fetch address (registered)
//   instr      env  -> core instruction at pc, combinational
//   dmem_we    core -> env  data-memory write strobe
//   dmem_addr  core -> env  data-memory address (0 when idle)
//   dmem_wd    core -> env  data-memory write data (0 when idle)
//   dmem_rd    env  -> core read data, one cycle after dmem_addr
//   halted     core -> env  HALT executed
//   fault      core -> env  stopped on a stack error
//   fault_code core -> env  01 DS under, 10 DS over, 11 RS error
//   ds_count   core -> env  data-stack occupancy
interface stack_cpu_core_if #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DS_DEPTH = 16
);
    localparam int unsigned DS_CW = $clog2(DS_DEPTH) + 1;

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
    logic             dmem_we;
    logic [WIDTH-1:0] dmem_addr;
    logic [WIDTH-1:0] dmem_wd;
    logic [WIDTH-1:0] dmem_rd;
    logic             halted;
    logic             fault;
    logic [1:0]       fault_code;
    logic [DS_CW-1:0] ds_count;

    modport master (
        output pc, dmem_we, dmem_addr, dmem_wd, halted, fault, fault_code, ds_count,
        input  instr, dmem_rd
    );

    modport slave (
        input  pc, dmem_we, dmem_addr, dmem_wd, halted, fault, fault_code, ds_count,
        output instr, dmem_rd
    );
endinterface

// File: rtl/stack_cpu_core.sv
// Two-stack (data + return) single-issue stack CPU core.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    stack_cpu_core_if.master: fetch, data memory and status signals
// Literals (MSB clear) push themselves; opcodes live in instr[3:0].
// Stack errors freeze the core in FAULT with a latched code; HALT freezes
// it in HALTED. Only reset leaves either state.
module stack_cpu_core #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DS_DEPTH = 16,
    parameter int unsigned RS_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    stack_cpu_core_if.master bus
);

    localparam int unsigned DS_AW = $clog2(DS_DEPTH);
    localparam int unsigned DS_CW = DS_AW + 1;
    localparam int unsigned RS_AW = $clog2(RS_DEPTH);
    localparam int unsigned RS_CW = RS_AW + 1;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_DROP  = 4'h1;
    localparam logic [3:0] OP_DUP   = 4'h2;
    localparam logic [3:0] OP_SWAP  = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_AND   = 4'h6;
    localparam logic [3:0] OP_XOR   = 4'h7;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_CALL  = 4'hC;
    localparam logic [3:0] OP_RET   = 4'hD;
    localparam logic [3:0] OP_TOR   = 4'hE;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_DS_UNDER = 2'b01;
    localparam logic [1:0] FC_DS_OVER  = 2'b10;
    localparam logic [1:0] FC_RS       = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD_WAIT,
        ST_HALTED,
        ST_FAULT
    } state_t;

    // Architectural state
    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ds [DS_DEPTH];
    logic [DS_CW-1:0] r_ds_cnt;
    logic [WIDTH-1:0] r_rs [RS_DEPTH];
    logic [RS_CW-1:0] r_rs_cnt;
    logic [1:0]       r_fault_code;

    // Next-state and control
    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [DS_CW-1:0] w_ds_cnt_nxt;
    logic [RS_CW-1:0] w_rs_cnt_nxt;
    logic [1:0]       w_fault_code_nxt;
    logic             w_ds_we_a;
    logic [DS_AW-1:0] w_ds_idx_a;
    logic [WIDTH-1:0] w_ds_wd_a;
    logic             w_ds_we_b;
    logic [DS_AW-1:0] w_ds_idx_b;
    logic [WIDTH-1:0] w_ds_wd_b;
    logic             w_rs_we;
    logic [WIDTH-1:0] w_rs_wd;
    logic             w_dm_we;
    logic [WIDTH-1:0] w_dm_addr;
    logic [WIDTH-1:0] w_dm_wd;

    // Operand access and hazard decode
    logic [DS_AW-1:0] w_t_idx;
    logic [DS_AW-1:0] w_s_idx;
    logic [DS_AW-1:0] w_push_idx;
    logic [RS_AW-1:0] w_rs_top_idx;
    logic [RS_AW-1:0] w_rs_push_idx;
    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_rs_top;
    logic [WIDTH-1:0] w_pc_inc;
    logic             w_is_op;
    logic [3:0]       w_op;
    logic             w_ds_full;
    logic             w_rs_full;
    logic             w_rs_empty;
    logic [1:0]       w_need;
    logic             w_grow;
    logic             w_rs_err;
    logic [1:0]       w_fcode;

    // Index arithmetic: out-of-range values only occur when the guarded
    // fault checks below already block the access.
    assign w_t_idx       = DS_AW'(r_ds_cnt - DS_CW'(1));
    assign w_s_idx       = DS_AW'(r_ds_cnt - DS_CW'(2));
    assign w_push_idx    = DS_AW'(r_ds_cnt);
    assign w_rs_top_idx  = RS_AW'(r_rs_cnt - RS_CW'(1));
    assign w_rs_push_idx = RS_AW'(r_rs_cnt);
    assign w_t           = r_ds[w_t_idx];
    assign w_s           = r_ds[w_s_idx];
    assign w_rs_top      = r_rs[w_rs_top_idx];
    assign w_pc_inc      = r_pc + WIDTH'(1);
    assign w_is_op       = bus.instr[WIDTH-1];
    assign w_op          = bus.instr[3:0];
    assign w_ds_full     = (r_ds_cnt == DS_CW'(DS_DEPTH));
    assign w_rs_full     = (r_rs_cnt == RS_CW'(RS_DEPTH));
    assign w_rs_empty    = (r_rs_cnt == '0);

    // Per-instruction stack requirements
    always_comb begin
        w_need   = 2'd0;
        w_grow   = 1'b0;
        w_rs_err = 1'b0;
        if (!w_is_op) begin
            w_grow = 1'b1;
        end else begin
            case (w_op)
                OP_DROP, OP_JMP, OP_LOAD: w_need = 2'd1;
                OP_DUP: begin
                    w_need = 2'd1;
                    w_grow = 1'b1;
                end
                OP_CALL, OP_TOR: begin
                    w_need   = 2'd1;
                    w_rs_err = w_rs_full;
                end
                OP_RET: w_rs_err = w_rs_empty;
                OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_STORE, OP_JZ: w_need = 2'd2;
                default: ;
            endcase
        end
    end

    // Fault priority: DS underflow, DS overflow, RS error
    always_comb begin
        w_fcode = FC_NONE;
        if (DS_CW'(w_need) > r_ds_cnt) begin
            w_fcode = FC_DS_UNDER;
        end else if (w_grow && w_ds_full) begin
            w_fcode = FC_DS_OVER;
        end else if (w_rs_err) begin
            w_fcode = FC_RS;
        end
    end

    // Next-state, datapath control and memory outputs
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ds_cnt_nxt     = r_ds_cnt;
        w_rs_cnt_nxt     = r_rs_cnt;
        w_fault_code_nxt = r_fault_code;
        w_ds_we_a        = 1'b0;
        w_ds_idx_a       = w_push_idx;
        w_ds_wd_a        = '0;
        w_ds_we_b        = 1'b0;
        w_ds_idx_b       = w_t_idx;
        w_ds_wd_b        = '0;
        w_rs_we          = 1'b0;
        w_rs_wd          = '0;
        w_dm_we          = 1'b0;
        w_dm_addr        = '0;
        w_dm_wd          = '0;

        unique case (r_state)
            ST_RUN: begin
                if (w_fcode != FC_NONE) begin
                    w_state_nxt      = ST_FAULT;
                    w_fault_code_nxt = w_fcode;
                end else if (!w_is_op) begin
                    w_ds_we_a    = 1'b1;
                    w_ds_wd_a    = bus.instr;
                    w_ds_cnt_nxt = r_ds_cnt + DS_CW'(1);
                    w_pc_nxt     = w_pc_inc;
                end else begin
                    case (w_op)
                        OP_NOP: w_pc_nxt = w_pc_inc;
                        OP_DROP: begin
                            w_ds_cnt_nxt = r_ds_cnt - DS_CW'(1);
                            w_pc_nxt     = w_pc_inc;
                        end
                        OP_DUP: begin
                            w_ds_we_a    = 1'b1;
                            w_ds_wd_a    = w_t;
                            w_ds_cnt_nxt = r_ds_cnt + DS_CW'(1);
                            w_pc_nxt     = w_pc_inc;
                        end
                        OP_SWAP: begin
                            w_ds_we_a  = 1'b1;
                            w_ds_idx_a = w_t_idx;
                            w_ds_wd_a  = w_s;
                            w_ds_we_b  = 1'b1;
                            w_ds_idx_b = w_s_idx;
                            w_ds_wd_b  = w_t;
                            w_pc_nxt   = w_pc_inc;
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_XOR: begin
                            w_ds_we_a  = 1'b1;
                            w_ds_idx_a = w_s_idx;
                            case (w_op)
                                OP_ADD:  w_ds_wd_a = w_s + w_t;
                                OP_SUB:  w_ds_wd_a = w_s - w_t;
                                OP_AND:  w_ds_wd_a = w_s & w_t;
                                default: w_ds_wd_a = w_s ^ w_t;
                            endcase
                            w_ds_cnt_nxt = r_ds_cnt - DS_CW'(1);
                            w_pc_nxt     = w_pc_inc;
                        end
                        OP_LOAD: begin
                            // Address goes out now; data arrives in LOAD_WAIT
                            w_dm_addr    = w_t;
                            w_ds_cnt_nxt = r_ds_cnt - DS_CW'(1);
                            w_state_nxt  = ST_LOAD_WAIT;
                        end
                        OP_STORE: begin
                            w_dm_we      = 1'b1;
                            w_dm_addr    = w_t;
                            w_dm_wd      = w_s;
                            w_ds_cnt_nxt = r_ds_cnt - DS_CW'(2);
                            w_pc_nxt     = w_pc_inc;
                        end
                        OP_JMP: begin
                            w_ds_cnt_nxt = r_ds_cnt - DS_CW'(1);
                            w_pc_nxt     = w_t;
                        end
                        OP_JZ: begin
                            w_ds_cnt_nxt = r_ds_cnt - DS_CW'(2);
                            w_pc_nxt     = (w_s == '0) ? w_t : w_pc_inc;
                        end
                        OP_CALL: begin
                            w_rs_we      = 1'b1;
                            w_rs_wd      = w_pc_inc;
                            w_rs_cnt_nxt = r_rs_cnt + RS_CW'(1);
                            w_ds_cnt_nxt = r_ds_cnt - DS_CW'(1);
                            w_pc_nxt     = w_t;
                        end
                        OP_RET: begin
                            w_rs_cnt_nxt = r_rs_cnt - RS_CW'(1);
                            w_pc_nxt     = w_rs_top;
                        end
                        OP_TOR: begin
                            w_rs_we      = 1'b1;
                            w_rs_wd      = w_t;
                            w_rs_cnt_nxt = r_rs_cnt + RS_CW'(1);
                            w_ds_cnt_nxt = r_ds_cnt - DS_CW'(1);
                            w_pc_nxt     = w_pc_inc;
                        end
                        OP_HALT: w_state_nxt = ST_HALTED;
                    endcase
                end
            end
            ST_LOAD_WAIT: begin
                // The LOAD already popped its address, so this push always fits
                w_ds_we_a    = 1'b1;
                w_ds_wd_a    = bus.dmem_rd;
                w_ds_cnt_nxt = r_ds_cnt + DS_CW'(1);
                w_pc_nxt     = w_pc_inc;
                w_state_nxt  = ST_RUN;
            end
            ST_HALTED, ST_FAULT: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Program counter, stack pointers and fault code
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc         <= '0;
            r_ds_cnt     <= '0;
            r_rs_cnt     <= '0;
            r_fault_code <= FC_NONE;
        end else begin
            r_pc         <= w_pc_nxt;
            r_ds_cnt     <= w_ds_cnt_nxt;
            r_rs_cnt     <= w_rs_cnt_nxt;
            r_fault_code <= w_fault_code_nxt;
        end
    end

    // Stack storage; contents are meaningless above the counts, so no reset
    always_ff @(posedge clk) begin
        if (w_ds_we_a) begin
            r_ds[w_ds_idx_a] <= w_ds_wd_a;
        end
        if (w_ds_we_b) begin
            r_ds[w_ds_idx_b] <= w_ds_wd_b;
        end
        if (w_rs_we) begin
            r_rs[w_rs_push_idx] <= w_rs_wd;
        end
    end

    assign bus.pc         = r_pc;
    assign bus.dmem_we    = w_dm_we;
    assign bus.dmem_addr  = w_dm_addr;
    assign bus.dmem_wd    = w_dm_wd;
    assign bus.halted     = (r_state == ST_HALTED);
    assign bus.fault      = (r_state == ST_FAULT);
    assign bus.fault_code = r_fault_code;
    assign bus.ds_count   = r_ds_cnt;

endmodule

// File: doc/stack_cpu_core.md
STACK_CPU_CORE -- requirements
Module: stack_cpu_core

Interface
REQ-001 Parameter WIDTH, default 16: data, address and instruction width in bits; values of 8 or more.
REQ-002 Parameter DS_DEPTH, default 16: data-stack entries; a power of 2, at least 2.
REQ-003 Parameter RS_DEPTH, default 8: return-stack entries; a power of 2, at least 2.
REQ-004 clk  in  1  single clock; every state element updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 pc  out  WIDTH  registered program counter (instruction fetch address).
REQ-007 instr  in  WIDTH  instruction at pc; combinational, valid in the same cycle.
REQ-008 dmem_we  out  1  data-memory write strobe.
REQ-009 dmem_addr  out  WIDTH  data-memory address.
REQ-010 dmem_wd  out  WIDTH  data-memory write data.
REQ-011 dmem_rd  in  WIDTH  data-memory read data; valid one cycle after dmem_addr is driven (synchronous RAM).
REQ-012 halted  out  1  core has executed HALT.
REQ-013 fault  out  1  core has stopped on a stack error.
REQ-014 fault_code  out  2  01 DS underflow, 10 DS overflow, 11 RS under/overflow, 00 none.
REQ-015 ds_count  out  clog2(DS_DEPTH)+1  current data-stack occupancy.

Function
REQ-016 States: RUN, LOAD_WAIT, HALTED, FAULT; exactly one instruction issues per RUN cycle.
REQ-017 instr[WIDTH-1]=0 is a literal: push instr (MSB zero), pc+1.
REQ-018 instr[WIDTH-1]=1 is an opcode in instr[3:0]; bits [WIDTH-2:4] are ignored.
REQ-019 Opcodes (T=top, S=second): 0 NOP; 1 DROP; 2 DUP; 3 SWAP; 4 ADD (S+T); 5 SUB (S-T); 6 AND; 7 XOR; results replace S,T with one entry.
REQ-020 Opcodes: 8 LOAD; 9 STORE (mem[T]<=S, pop 2); A JMP (pc<=T, pop); B JZ (pop T,S; pc<=T if S==0, else pc+1); C CALL (RS push pc+1, pc<=T, pop); D RET (pc<=RS top, RS pop); E TOR (RS push T, DS pop); F HALT.
REQ-021 Arithmetic and pc increment wrap modulo 2^WIDTH; no carry or flags.
REQ-022 LOAD: RUN cycle drives dmem_addr=T and pops T, pc held, goes to LOAD_WAIT; LOAD_WAIT pushes dmem_rd, pc+1, returns to RUN. Load latency is 2 cycles.
REQ-023 STORE: dmem_we=1 for exactly the issuing cycle, with dmem_addr=T and dmem_wd=S; dmem_we=0 in every other cycle.
REQ-024 dmem_addr and dmem_wd are 0 whenever they are not in use.
REQ-025 Required DS entries: DROP, DUP, JMP, CALL, TOR, LOAD need 1; SWAP, ADD, SUB, AND, XOR, STORE, JZ need 2.
REQ-026 Fewer DS entries than required causes DS underflow.
REQ-027 A net DS push when DS is full (literal, DUP) causes DS overflow; SWAP and binary ops on a full stack are legal.
REQ-028 RET on an empty RS, or CALL/TOR on a full RS, causes an RS fault.
REQ-029 A faulting instruction has no effect: no stack, pc or memory change and dmem_we=0; the state goes to FAULT and fault_code is latched. Precedence: DS underflow, then DS overflow, then RS.
REQ-030 HALT: halted=1 and pc holds at the HALT address.
REQ-031 HALTED and FAULT are absorbing: instr is ignored and only reset exits them.
REQ-032 Stacks are internal register arrays; no wrap-around, and occupancy never exceeds its depth.

Reset
REQ-033 reset=1 at a clock edge sets: pc=0, both stacks empty, state RUN, halted=0, fault=0, fault_code=00, ds_count=0.
REQ-034 Reset overrides everything, including mid-LOAD_WAIT (the pending load is discarded) and HALTED/FAULT.
REQ-035 reset takes effect on the clock edge only; outputs show reset values from that edge on.

Verification
REQ-036 Bench drives literals 5, 3, then ADD -> ds_count=1, T=8; then literal 10, SUB -> T=0xFFFE (WIDTH=16).
REQ-037 Bench drives literals 0x55, 0x20, STORE -> dmem_we=1, dmem_addr=0x20, dmem_wd=0x55 for one cycle; then literal 0x20, LOAD with dmem_rd=0x55 -> T=0x55 after 2 cycles, pc advanced by 1.
REQ-038 At pc=4, bench drives literal 0x40, CALL -> pc=0x40, RS top=6; RET at 0x40 -> pc=6.
REQ-039 Bench drives literals 0, 0x30, JZ -> pc=0x30; literals 1, 0x30, JZ -> pc advances by 1.
REQ-040 Bench pushes DS_DEPTH literals, then one more -> fault=1, fault_code=10, ds_count=DS_DEPTH, pc frozen; DROP on an empty stack after reset -> fault_code=01.
REQ-041 Bench asserts reset during LOAD_WAIT and again while HALTED -> pc=0, ds_count=0, halted=0, state RUN on the next cycle.
